// File: rtl/ctrl_fsm_exec.sv
// Fetch/decode/execute control FSM for the accumulator datapath.
// Ports: clk/reset, opcode + NFLG/ZFLG in; fetch, PC/AC/IR/mem strobes, ALU_OP, HALTED, ILLEGAL, STATE out.
module ctrl_fsm_exec #(
  parameter int OPW      = 8,
  parameter int IR_BYTES = 2,
  parameter int MEM_WAIT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPW-1:0]      opcode,
  input  logic                NFLG,
  input  logic                ZFLG,
  output logic                fetch,
  output logic                INCR_PC,
  output logic                LOAD_PC,
  output logic                LOAD_AC,
  output logic [IR_BYTES-1:0] LOAD_IR,
  output logic                STORE_MEM,
  output logic                MEM_SEL,
  output logic [1:0]          ALU_OP,
  output logic                HALTED,
  output logic                ILLEGAL,
  output logic [2:0]          STATE
);

  typedef enum logic [2:0] {
    S_START  = 3'd0,
    S_PREP   = 3'd1,
    S_FETCH  = 3'd2,
    S_DECODE = 3'd3,
    S_MEMRD  = 3'd4,
    S_EXEC   = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [3:0] C_NOP   = 4'h0;
  localparam logic [3:0] C_LOADI = 4'h1;
  localparam logic [3:0] C_LOAD  = 4'h2;
  localparam logic [3:0] C_STORE = 4'h3;
  localparam logic [3:0] C_ADD   = 4'h4;
  localparam logic [3:0] C_SUB   = 4'h5;
  localparam logic [3:0] C_JMP   = 4'h6;
  localparam logic [3:0] C_JN    = 4'h7;
  localparam logic [3:0] C_JZ    = 4'h8;
  localparam logic [3:0] C_HALT  = 4'hF;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  localparam logic [1:0] IDX_LAST = 2'(IR_BYTES - 1);
  localparam logic [2:0] WAIT_LAST =
    (MEM_WAIT > 0) ? 3'(MEM_WAIT - 1) : 3'd0;

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [2:0] wait_q, wait_d;
  logic [3:0] cls_q, cls_d;
  logic [3:0] cls_in;

  // Only the class nibble is decoded; low opcode bits belong to the datapath.
  logic unused_op;
  assign unused_op = ^opcode;
  assign cls_in    = opcode[OPW-1 -: 4];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_START;
      idx_q   <= 2'd0;
      wait_q  <= 3'd0;
      cls_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      cls_q   <= cls_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    cls_d     = cls_q;
    fetch     = 1'b0;
    INCR_PC   = 1'b0;
    LOAD_PC   = 1'b0;
    LOAD_AC   = 1'b0;
    LOAD_IR   = '0;
    STORE_MEM = 1'b0;
    MEM_SEL   = 1'b0;
    ALU_OP    = ALU_PASS;
    HALTED    = 1'b0;
    ILLEGAL   = 1'b0;
    STATE     = state_q;

    unique case (state_q)
      S_START: state_d = S_PREP;

      S_PREP: begin
        fetch   = 1'b1;
        state_d = S_FETCH;
      end

      S_FETCH: begin
        fetch   = 1'b1;
        INCR_PC = 1'b1;
        LOAD_IR = IR_BYTES'(1) << idx_q;
        if (idx_q == IDX_LAST) begin
          idx_d   = 2'd0;
          state_d = S_DECODE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = S_PREP;
        end
      end

      S_DECODE: begin
        // Latch the class so later opcode changes cannot alter EXEC.
        cls_d  = cls_in;
        wait_d = 3'd0;
        case (cls_in)
          C_NOP: state_d = S_PREP;
          C_LOADI, C_STORE, C_JMP, C_JN, C_JZ:
            state_d = S_EXEC;
          C_LOAD, C_ADD, C_SUB:
            state_d = (MEM_WAIT > 0) ? S_MEMRD : S_EXEC;
          C_HALT: state_d = S_HALT;
          default: begin
            ILLEGAL = 1'b1;
            state_d = S_PREP;
          end
        endcase
      end

      S_MEMRD: begin
        MEM_SEL = 1'b1;
        if (wait_q == WAIT_LAST) begin
          wait_d  = 3'd0;
          state_d = S_EXEC;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end

      S_EXEC: begin
        state_d = S_PREP;
        case (cls_q)
          C_LOADI: LOAD_AC = 1'b1;
          C_LOAD: begin
            LOAD_AC = 1'b1;
            MEM_SEL = 1'b1;
          end
          C_ADD: begin
            LOAD_AC = 1'b1;
            MEM_SEL = 1'b1;
            ALU_OP  = ALU_ADD;
          end
          C_SUB: begin
            LOAD_AC = 1'b1;
            MEM_SEL = 1'b1;
            ALU_OP  = ALU_SUB;
          end
          C_STORE: begin
            STORE_MEM = 1'b1;
            MEM_SEL   = 1'b1;
          end
          C_JMP:   LOAD_PC = 1'b1;
          C_JN:    LOAD_PC = NFLG;
          C_JZ:    LOAD_PC = ZFLG;
          default: ;
        endcase
      end

      S_HALT: HALTED = 1'b1;

      default: state_d = S_START;
    endcase
  end

endmodule

// File: tb/tb_ctrl_fsm_exec.sv
// Directed bench for ctrl_fsm_exec.
// Three instances share stimulus: A(IR=2,W=2), B(IR=2,W=0), C(IR=3,W=1).
module tb_ctrl_fsm_exec;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] opcode = 8'h00;
  logic       NFLG = 1'b0;
  logic       ZFLG = 1'b0;

  logic       a_fetch, a_incr, a_ldpc, a_ldac, a_st, a_msel;
  logic       a_halt, a_ill;
  logic [1:0] a_ir, a_alu;
  logic [2:0] a_state;

  logic       b_fetch, b_incr, b_ldpc, b_ldac, b_st, b_msel;
  logic       b_halt, b_ill;
  logic [1:0] b_ir, b_alu;
  logic [2:0] b_state;

  logic       c_fetch, c_incr, c_ldpc, c_ldac, c_st, c_msel;
  logic       c_halt, c_ill;
  logic [2:0] c_ir;
  logic [1:0] c_alu;
  logic [2:0] c_state;

  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  ctrl_fsm_exec #(.OPW(8), .IR_BYTES(2), .MEM_WAIT(2)) u_a (
    .clk(clk), .reset(reset), .opcode(opcode),
    .NFLG(NFLG), .ZFLG(ZFLG),
    .fetch(a_fetch), .INCR_PC(a_incr), .LOAD_PC(a_ldpc),
    .LOAD_AC(a_ldac), .LOAD_IR(a_ir), .STORE_MEM(a_st),
    .MEM_SEL(a_msel), .ALU_OP(a_alu), .HALTED(a_halt),
    .ILLEGAL(a_ill), .STATE(a_state)
  );

  ctrl_fsm_exec #(.OPW(8), .IR_BYTES(2), .MEM_WAIT(0)) u_b (
    .clk(clk), .reset(reset), .opcode(opcode),
    .NFLG(NFLG), .ZFLG(ZFLG),
    .fetch(b_fetch), .INCR_PC(b_incr), .LOAD_PC(b_ldpc),
    .LOAD_AC(b_ldac), .LOAD_IR(b_ir), .STORE_MEM(b_st),
    .MEM_SEL(b_msel), .ALU_OP(b_alu), .HALTED(b_halt),
    .ILLEGAL(b_ill), .STATE(b_state)
  );

  ctrl_fsm_exec #(.OPW(8), .IR_BYTES(3), .MEM_WAIT(1)) u_c (
    .clk(clk), .reset(reset), .opcode(opcode),
    .NFLG(NFLG), .ZFLG(ZFLG),
    .fetch(c_fetch), .INCR_PC(c_incr), .LOAD_PC(c_ldpc),
    .LOAD_AC(c_ldac), .LOAD_IR(c_ir), .STORE_MEM(c_st),
    .MEM_SEL(c_msel), .ALU_OP(c_alu), .HALTED(c_halt),
    .ILLEGAL(c_ill), .STATE(c_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] es [5];
    logic [1:0] ei [5];
    logic [12:0] va;
    es = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd3};
    ei = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    opcode = 8'h00;
    reset = 1'b1;
    step();
    step();
    va = {a_fetch, a_incr, a_ldpc, a_ldac, a_ir, a_st,
          a_msel, a_alu, a_halt, a_ill, a_state[1:0]};
    total++;
    if (va !== 13'd0 || a_state !== 3'd0)
      $display("FAIL reset_a outs=%h st=%0d want 0", va, a_state);
    else pass_cnt++;
    total++;
    if ({c_ir, c_fetch, c_incr, c_state} !== 8'd0)
      $display("FAIL reset_c ir=%b st=%0d want 0", c_ir, c_state);
    else pass_cnt++;
    reset = 1'b0;
    step();
    step();
    total++;
    if (a_state !== 3'd2)
      $display("FAIL pre_reset_fetch st=%0d want 2", a_state);
    else pass_cnt++;
    reset = 1'b1;
    step();
    va = {a_fetch, a_incr, a_ldpc, a_ldac, a_ir, a_st,
          a_msel, a_alu, a_halt, a_ill, a_state[1:0]};
    total++;
    if (va !== 13'd0 || a_state !== 3'd0)
      $display("FAIL reset_mid_fetch outs=%h st=%0d want 0",
               va, a_state);
    else pass_cnt++;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (a_state !== es[i] || a_ir !== ei[i])
        $display("FAIL reset_seq[%0d] st=%0d ir=%b want %0d %b",
                 i, a_state, a_ir, es[i], ei[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_loadi();
    logic [2:0] es [7];
    int ninc;
    es = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    ninc = 0;
    opcode = 8'h10;
    restart();
    for (int i = 0; i < 7; i++) begin
      step();
      if (a_incr === 1'b1) ninc++;
      total++;
      if (a_state !== es[i])
        $display("FAIL loadi_st[%0d] got %0d want %0d",
                 i, a_state, es[i]);
      else pass_cnt++;
      if (i == 4) begin
        total++;
        if (a_ill !== 1'b0)
          $display("FAIL loadi_illegal got %b want 0", a_ill);
        else pass_cnt++;
      end
      if (i == 5) begin
        total++;
        if ({a_ldac, a_alu, a_msel, a_st, a_ldpc} !== 6'b100000)
          $display("FAIL loadi_exec got %b want 100000",
                   {a_ldac, a_alu, a_msel, a_st, a_ldpc});
        else pass_cnt++;
      end
    end
    total++;
    if (ninc != 2)
      $display("FAIL loadi_incr got %0d want 2", ninc);
    else pass_cnt++;
  endtask

  task automatic test_add();
    logic [2:0] ea [9];
    logic [2:0] eb [9];
    ea = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd1};
    eb = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1, 3'd2, 3'd1};
    opcode = 8'h40;
    restart();
    for (int i = 0; i < 9; i++) begin
      step();
      total++;
      if (a_state !== ea[i] || b_state !== eb[i])
        $display("FAIL add_st[%0d] got %0d/%0d want %0d/%0d",
                 i, a_state, b_state, ea[i], eb[i]);
      else pass_cnt++;
      if (i == 5 || i == 6) begin
        total++;
        if ({a_msel, a_ldac} !== 2'b10)
          $display("FAIL add_memrd[%0d] sel/ldac=%b want 10",
                   i, {a_msel, a_ldac});
        else pass_cnt++;
      end
      if (i == 7) begin
        total++;
        if ({a_ldac, a_alu, a_msel} !== 4'b1011)
          $display("FAIL add_exec_a got %b want 1011",
                   {a_ldac, a_alu, a_msel});
        else pass_cnt++;
      end
      if (i == 5) begin
        total++;
        if ({b_ldac, b_alu, b_msel} !== 4'b1011)
          $display("FAIL add_exec_b got %b want 1011",
                   {b_ldac, b_alu, b_msel});
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_branch();
    logic [7:0] ops [5];
    logic       nf [5];
    logic       zf [5];
    logic       ex [5];
    ops = '{8'h80, 8'h80, 8'h70, 8'h70, 8'h60};
    nf  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    zf  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ex  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      opcode = ops[k];
      NFLG = nf[k];
      ZFLG = zf[k];
      restart();
      repeat (6) step();
      total++;
      if (a_state !== 3'd5 || a_ldpc !== ex[k] ||
          a_incr !== 1'b0 || a_ldac !== 1'b0)
        $display("FAIL br_exec[%0d] st=%0d ldpc=%b want 5 %b",
                 k, a_state, a_ldpc, ex[k]);
      else pass_cnt++;
      opcode = 8'h00;
      #1;
      total++;
      if (a_ldpc !== ex[k])
        $display("FAIL br_opchg[%0d] ldpc=%b want %b",
                 k, a_ldpc, ex[k]);
      else pass_cnt++;
      step();
      total++;
      if (a_state !== 3'd1 || a_ldpc !== 1'b0)
        $display("FAIL br_after[%0d] st=%0d ldpc=%b want 1 0",
                 k, a_state, a_ldpc);
      else pass_cnt++;
    end
    NFLG = 1'b0;
    ZFLG = 1'b0;
  endtask

  task automatic test_illegal();
    opcode = 8'hA0;
    restart();
    repeat (4) step();
    total++;
    if (a_ill !== 1'b0)
      $display("FAIL ill_fetch got %b want 0", a_ill);
    else pass_cnt++;
    step();
    total++;
    if (a_state !== 3'd3 || a_ill !== 1'b1 ||
        {a_ldac, a_st, a_ldpc} !== 3'b000)
      $display("FAIL ill_decode st=%0d ill=%b want 3 1",
               a_state, a_ill);
    else pass_cnt++;
    step();
    total++;
    if (a_state !== 3'd1 || a_ill !== 1'b0 ||
        {a_ldac, a_st, a_ldpc} !== 3'b000)
      $display("FAIL ill_next st=%0d ill=%b want 1 0",
               a_state, a_ill);
    else pass_cnt++;
  endtask

  task automatic test_halt();
    opcode = 8'hF0;
    restart();
    repeat (6) step();
    for (int i = 0; i < 20; i++) begin
      total++;
      if (a_state !== 3'd6 || a_halt !== 1'b1 ||
          a_fetch !== 1'b0 || a_incr !== 1'b0)
        $display("FAIL halt[%0d] st=%0d h=%b f=%b want 6 1 0",
                 i, a_state, a_halt, a_fetch);
      else pass_cnt++;
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if (a_state !== 3'd0 || a_halt !== 1'b0)
      $display("FAIL halt_reset st=%0d h=%b want 0 0",
               a_state, a_halt);
    else pass_cnt++;
  endtask

  task automatic test_ir3_store();
    logic [2:0] es [9];
    logic [2:0] ei [9];
    int ninc;
    es = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    ei = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000,
           3'b100, 3'b000, 3'b000, 3'b000};
    ninc = 0;
    opcode = 8'h30;
    restart();
    for (int i = 0; i < 9; i++) begin
      step();
      if (c_incr === 1'b1) ninc++;
      total++;
      if (c_state !== es[i] || c_ir !== ei[i])
        $display("FAIL ir3_seq[%0d] st=%0d ir=%b want %0d %b",
                 i, c_state, c_ir, es[i], ei[i]);
      else pass_cnt++;
      if (i == 7) begin
        total++;
        if ({c_st, c_msel, c_ldac, c_ldpc} !== 4'b1100)
          $display("FAIL ir3_exec got %b want 1100",
                   {c_st, c_msel, c_ldac, c_ldpc});
        else pass_cnt++;
      end
    end
    total++;
    if (ninc != 3)
      $display("FAIL ir3_incr got %0d want 3", ninc);
    else pass_cnt++;
  endtask

  task automatic test_sub_memrd_reset();
    logic [2:0] es [10];
    es = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd1,
           3'd2, 3'd3, 3'd4, 3'd5, 3'd1};
    opcode = 8'h50;
    restart();
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (c_state !== es[i])
        $display("FAIL sub_st[%0d] got %0d want %0d",
                 i, c_state, es[i]);
      else pass_cnt++;
      if (i == 8) begin
        total++;
        if ({c_ldac, c_alu, c_msel} !== 4'b1101)
          $display("FAIL sub_exec got %b want 1101",
                   {c_ldac, c_alu, c_msel});
        else pass_cnt++;
      end
    end
    opcode = 8'h20;
    restart();
    repeat (6) step();
    total++;
    if (a_state !== 3'd4 || a_msel !== 1'b1)
      $display("FAIL ld_memrd st=%0d sel=%b want 4 1",
               a_state, a_msel);
    else pass_cnt++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if (a_state !== 3'd0 || a_msel !== 1'b0)
      $display("FAIL reset_mid_memrd st=%0d want 0", a_state);
    else pass_cnt++;
    step();
    total++;
    if (a_state !== 3'd1 || a_fetch !== 1'b1)
      $display("FAIL memrd_restart st=%0d want 1", a_state);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_loadi();
    test_add();
    test_branch();
    test_illegal();
    test_halt();
    test_ir3_store();
    test_sub_memrd_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm_exec.md
Name: ctrl_fsm_exec

Overview:
Parametrised fetch/decode/execute control unit for the accumulator datapath. It fetches a configurable number of instruction bytes per instruction and decodes the opcode class. It then drives single-cycle datapath strobes for load, store, ALU and branch operations, with a configurable memory-read wait. Sits between program memory/IR and the AC/PC/ALU datapath.

Parameters:
OPW, 8, opcode width in bits (min 4); class = opcode[OPW-1 -: 4]
IR_BYTES, 2, instruction bytes fetched per instruction (1..4)
MEM_WAIT, 1, extra memory-read cycles before AC load for LOAD/ADD/SUB (0..7)

Ports:
clk  in  1  clock, all state changes on posedge
reset  in  1  synchronous, active-high
opcode  in  OPW  opcode from IR byte 0, valid from DECODE onward
NFLG  in  1  accumulator negative flag
ZFLG  in  1  accumulator zero flag
fetch  out  1  high in PREP and FETCH (memory addressed by PC)
INCR_PC  out  1  PC increment strobe
LOAD_PC  out  1  PC load-from-operand strobe
LOAD_AC  out  1  AC load strobe
LOAD_IR  out  IR_BYTES  one-hot IR byte load strobe, bit i loads byte i
STORE_MEM  out  1  memory write strobe (AC -> mem[operand])
MEM_SEL  out  1  0 = address from PC, 1 = address from IR operand
ALU_OP  out  2  00 PASS, 01 ADD, 10 SUB, 11 reserved (never driven)
HALTED  out  1  high while in HALT
ILLEGAL  out  1  one-cycle pulse on undefined opcode class
STATE  out  3  current state encoding

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: sampled on posedge. The next state is START from any state, including mid-fetch and mid-MEMRD. Byte index and wait counter are cleared to 0.
- Outputs are Moore (decoded from registered state and counters). The exceptions are LOAD_PC in EXEC for JN/JZ and ILLEGAL in DECODE.
- State encoding: START=0, PREP=1, FETCH=2, DECODE=3, MEMRD=4, EXEC=5, HALT=6. Code 7 is unreachable and recovers to START on the next edge.
- In START: all outputs 0, STATE=0. Reset values of all outputs equal the START values.
- START -> PREP after 1 cycle.
- PREP: fetch=1, MEM_SEL=0. Next state is FETCH.
- FETCH: fetch=1, INCR_PC=1, LOAD_IR[idx]=1.
  - If idx==IR_BYTES-1: idx<=0, next state is DECODE.
  - Otherwise: idx<=idx+1, next state is PREP.
- DECODE: 1 cycle, no strobes. Class decode and next state:
  - 0x0 NOP -> PREP
  - 0x1 LOADI, 0x3 STORE, 0x6 JMP, 0x7 JN, 0x8 JZ -> EXEC
  - 0x2 LOAD, 0x4 ADD, 0x5 SUB -> MEMRD if MEM_WAIT>0, else EXEC
  - 0xF HALT -> HALT
  - Any other class: ILLEGAL=1 this cycle -> PREP (behaves as NOP)
- MEMRD: MEM_SEL=1 for exactly MEM_WAIT cycles (wait counter), then EXEC.
- EXEC: exactly 1 cycle, then PREP. Outputs by class:
  - LOADI: LOAD_AC=1, ALU_OP=PASS, MEM_SEL=0
  - LOAD: LOAD_AC=1, ALU_OP=PASS, MEM_SEL=1
  - ADD: LOAD_AC=1, ALU_OP=ADD, MEM_SEL=1
  - SUB: LOAD_AC=1, ALU_OP=SUB, MEM_SEL=1
  - STORE: STORE_MEM=1, MEM_SEL=1
  - JMP: LOAD_PC=1
  - JN: LOAD_PC=NFLG
  - JZ: LOAD_PC=ZFLG
  - Flags are sampled combinationally during EXEC only.
- opcode is registered internally in DECODE. Changes to opcode after DECODE do not affect EXEC.
- HALT: HALTED=1, all other strobes 0, fetch=0. Held until reset.
- At most one of LOAD_AC, STORE_MEM, LOAD_PC is high in any cycle. INCR_PC and LOAD_PC are never high together.
- Cycles per instruction (excluding START):
  - 2*IR_BYTES + 1 for NOP and illegal classes
  - 2*IR_BYTES + 2 for LOADI, STORE, JMP, JN, JZ
  - 2*IR_BYTES + 2 + MEM_WAIT for LOAD, ADD, SUB

Test Plan:
1. Reset: IR_BYTES=2. Assert reset for 1 cycle while STATE=2 -> STATE=0 and all strobes 0 on the next edge. After release, STATE sequence is 1,2,1,2,3 and LOAD_IR goes 01 then 10.
2. LOADI: opcode=0x10, IR_BYTES=2 -> INCR_PC pulses twice, then DECODE, then EXEC with LOAD_AC=1, ALU_OP=00, MEM_SEL=0. STATE returns to 1 after 6 cycles.
3. ADD: opcode=0x40, MEM_WAIT=2 -> MEMRD for 2 cycles with MEM_SEL=1, then EXEC with LOAD_AC=1, ALU_OP=01. Total 8 cycles. With MEM_WAIT=0, DECODE goes straight to EXEC (6 cycles).
4. Branches:
   - JZ (0x80) with ZFLG=0 -> LOAD_PC=0 in EXEC. Repeat with ZFLG=1 -> LOAD_PC=1 for exactly 1 cycle.
   - JN (0x70) with NFLG=1 -> LOAD_PC=1.
   - Change opcode to 0x00 during EXEC -> no effect.
5. Illegal and halt:
   - opcode=0xA0 -> ILLEGAL=1 for 1 cycle in DECODE. LOAD_AC, STORE_MEM and LOAD_PC stay 0. Next state PREP.
   - opcode=0xF0 -> STATE=6, HALTED=1, fetch=0 held for 20 cycles. reset=1 returns STATE to 0.
6. IR_BYTES=3, STORE (0x30) -> LOAD_IR goes 001, 010, 100 and INCR_PC pulses 3 times. EXEC has STORE_MEM=1, MEM_SEL=1. Total 8 cycles.
